sequenciador_envio_serial: RTL

SEQUENCIADOR_ENVIO_SERIAL -- requirements
Module: sequenciador_envio_serial

---
 rtl/sequenciador_envio_serial.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sequenciador_envio_serial.sv
`timescale 1ns / 1ps
// sequenciador_envio_serial
// Builds and sends one status frame over a byte-wide UART each time the elevator
// changes floor. Frame: header {A, 00, floor}, NUM_CONTEUDO content bytes,
// NUM_FILA queue bytes, then the XOR of every previous byte of the frame.
//
// Ports
//   clock, reset                 clock (rising edge) and async active-high reset
//   mudou_de_andar               floor-change level; a rising edge requests a frame
//   andar_atual                  current floor, copied into the header
//   dados_conteudo_elevador      content RAM data {tipo, destino}
//   dados_fila_elevador          queue RAM data {tipo, origem, destino}
//   eh_origem_fila_elevador      origin flag of the addressed queue entry
//   uart_pronto                  UART finished the current byte (1-cycle pulse)
//   addr_conteudo_elevador       content RAM read address
//   addr_fila_elevador           queue RAM read address
//   uart_partida                 1-cycle start pulse to the UART
//   uart_dados                   byte to transmit
//   ocupado                      frame in progress (header through fim_envio)
//   fim_envio                    1-cycle pulse once the checksum byte is sent
module sequenciador_envio_serial #(
    parameter int unsigned NUM_CONTEUDO = 8,
    parameter int unsigned NUM_FILA     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mudou_de_andar,
    input  logic [1:0] andar_atual,
    input  logic [3:0] dados_conteudo_elevador,
    input  logic [5:0] dados_fila_elevador,
    input  logic       eh_origem_fila_elevador,
    input  logic       uart_pronto,
    output logic [3:0] addr_conteudo_elevador,
    output logic [3:0] addr_fila_elevador,
    output logic       uart_partida,
    output logic [7:0] uart_dados,
    output logic       ocupado,
    output logic       fim_envio
);

    localparam int unsigned NumRam = NUM_CONTEUDO + NUM_FILA;
    localparam int unsigned CntW   = $clog2(NumRam + 2);

    localparam logic [CntW-1:0] CntConteudo = CntW'(NUM_CONTEUDO);
    localparam logic [CntW-1:0] CntRam      = CntW'(NumRam);
    localparam logic [CntW-1:0] CntFim      = CntW'(NumRam + 1);

    localparam logic [2:0] OCIOSO      = 3'd0;
    localparam logic [2:0] CABECALHO   = 3'd1;
    localparam logic [2:0] LE_RAM      = 3'd2;
    localparam logic [2:0] ESPERA_RAM  = 3'd3;
    localparam logic [2:0] CARREGA     = 3'd4;
    localparam logic [2:0] ESPERA_UART = 3'd5;
    localparam logic [2:0] CHECKSUM    = 3'd6;

    logic [2:0]      estado_q, estado_d;
    // RAM bytes already loaded; NumRam+1 marks the checksum as sent
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      dados_q, dados_d;
    logic [7:0]      soma_q, soma_d;
    logic            pend_q, pend_d;
    logic            fim_q, fim_d;
    logic            mudou_q;
    // Set once the level has been seen low since reset, so a level held high
    // across reset release is not taken as an edge.
    logic            armado_q;
    logic            borda;

    assign borda = mudou_de_andar & ~mudou_q & armado_q;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        dados_d  = dados_q;
        soma_d   = soma_q;
        pend_d   = pend_q;
        fim_d    = 1'b0;

        if (borda) begin
            pend_d = 1'b1;
        end

        case (estado_q)
            OCIOSO: begin
                // Covers an edge arriving in the fim_envio cycle as well.
                if (borda || pend_q) begin
                    estado_d = CABECALHO;
                    pend_d   = 1'b0;
                    soma_d   = 8'h00;
                    cnt_d    = '0;
                    dados_d  = {4'hA, 2'b00, andar_atual};
                end
            end
            CABECALHO: begin
                soma_d   = soma_q ^ dados_q;
                estado_d = ESPERA_UART;
            end
            LE_RAM: begin
                estado_d = ESPERA_RAM;
            end
            ESPERA_RAM: begin
                if (cnt_q < CntConteudo) begin
                    dados_d = {4'b0100, dados_conteudo_elevador};
                end else begin
                    dados_d = {1'b1, eh_origem_fila_elevador, dados_fila_elevador};
                end
                estado_d = CARREGA;
            end
            CARREGA: begin
                soma_d   = soma_q ^ dados_q;
                cnt_d    = cnt_q + 1'b1;
                estado_d = ESPERA_UART;
            end
            ESPERA_UART: begin
                if (uart_pronto) begin
                    if (cnt_q < CntRam) begin
                        estado_d = LE_RAM;
                    end else if (cnt_q == CntRam) begin
                        estado_d = CHECKSUM;
                        dados_d  = soma_q;
                    end else begin
                        estado_d = OCIOSO;
                        fim_d    = 1'b1;
                        cnt_d    = '0;
                    end
                end
            end
            CHECKSUM: begin
                cnt_d    = CntFim;
                estado_d = ESPERA_UART;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            cnt_q    <= '0;
            dados_q  <= 8'h00;
            soma_q   <= 8'h00;
            pend_q   <= 1'b0;
            fim_q    <= 1'b0;
            mudou_q  <= 1'b0;
            armado_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            dados_q  <= dados_d;
            soma_q   <= soma_d;
            pend_q   <= pend_d;
            fim_q    <= fim_d;
            mudou_q  <= mudou_de_andar;
            armado_q <= armado_q | ~mudou_de_andar;
        end
    end

    // Addresses follow the byte counter and saturate at the last entry of
    // each RAM until the counter returns to 0 at frame end.
    assign addr_conteudo_elevador = (cnt_q < CntConteudo) ? 4'(cnt_q) : 4'(NUM_CONTEUDO - 1);
    assign addr_fila_elevador     = (cnt_q < CntConteudo) ? 4'd0 :
                                    (cnt_q < CntRam)      ? 4'(cnt_q - CntConteudo) :
                                                            4'(NUM_FILA - 1);

    assign uart_partida = (estado_q == CABECALHO) || (estado_q == CARREGA) ||
                          (estado_q == CHECKSUM);
    assign uart_dados   = dados_q;
    assign ocupado      = (estado_q != OCIOSO) || fim_q;
    assign fim_envio    = fim_q;

endmodule
